// File: rtl/mem_arbiter.sv
// Word-request arbiter between per-CPU I/D caches and one RAM port.
// D requests outrank I requests; CPUs rotate round-robin within a class.
module mem_arbiter #(
   parameter int CPUS   = 2,
   parameter int WORD_W = 32
) (
   input  logic                          clk,
   input  logic                          RST,
   input  logic [CPUS-1:0]               iREN,
   input  logic [CPUS-1:0][WORD_W-1:0]   iaddr,
   output logic [CPUS-1:0]               iwait,
   output logic [CPUS-1:0][WORD_W-1:0]   iload,
   input  logic [CPUS-1:0]               dREN,
   input  logic [CPUS-1:0]               dWEN,
   input  logic [CPUS-1:0][WORD_W-1:0]   daddr,
   input  logic [CPUS-1:0][WORD_W-1:0]   dstore,
   output logic [CPUS-1:0]               dwait,
   output logic [CPUS-1:0][WORD_W-1:0]   dload,
   output logic                          ramREN,
   output logic                          ramWEN,
   output logic [WORD_W-1:0]             ramaddr,
   output logic [WORD_W-1:0]             ramstore,
   input  logic [WORD_W-1:0]             ramload,
   input  logic [1:0]                    ramstate
);

   localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   typedef enum logic {IDLE, XFER} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_grant_cpu;
   logic            r_grant_is_d;
   logic            r_grant_is_wr;
   logic [CW-1:0]   r_rr_ptr;

   logic [CPUS-1:0] w_dreq;
   logic            w_any_d;
   logic [CPUS-1:0] w_req;
   logic            w_found;
   logic [CW-1:0]   w_pick;
   logic [CW-1:0]   w_cand;
   int              w_idx;
   logic            w_gnt_req;
   logic            w_done;

   assign w_dreq  = dREN | dWEN;
   assign w_any_d = |w_dreq;
   assign w_req   = w_any_d ? w_dreq : iREN;

   // Scan starts just past the last CPU served.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = 0;
      w_cand  = '0;
      for (int k = 1; k <= CPUS; k++) begin
         w_idx  = (int'(r_rr_ptr) + k) % CPUS;
         w_cand = CW'(w_idx);
         if (!w_found && w_req[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   assign w_gnt_req = r_grant_is_d ? w_dreq[r_grant_cpu]
                                   : iREN[r_grant_cpu];
   assign w_done    = (r_state == XFER) && (ramstate == RS_ACCESS) && !RST;

   always_ff @(posedge clk) begin
      if (RST) begin
         r_state       <= IDLE;
         r_grant_cpu   <= '0;
         r_grant_is_d  <= 1'b0;
         r_grant_is_wr <= 1'b0;
         r_rr_ptr      <= CW'(CPUS - 1);
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant_cpu   <= w_pick;
                  r_grant_is_d  <= w_any_d;
                  r_grant_is_wr <= w_any_d & dWEN[w_pick];
                  r_state       <= XFER;
               end
            end
            XFER: begin
               if (ramstate == RS_ACCESS) begin
                  r_rr_ptr <= r_grant_cpu;
                  r_state  <= IDLE;
               end else if (ramstate == RS_ERROR || !w_gnt_req) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if (r_state == XFER) begin
         ramREN  = !r_grant_is_wr;
         ramWEN  = r_grant_is_wr;
         ramaddr = r_grant_is_d ? daddr[r_grant_cpu] : iaddr[r_grant_cpu];
         if (r_grant_is_wr)
            ramstore = dstore[r_grant_cpu];
      end
   end

   always_comb begin
      iwait = '1;
      dwait = '1;
      if (w_done) begin
         if (r_grant_is_d)
            dwait[r_grant_cpu] = 1'b0;
         else
            iwait[r_grant_cpu] = 1'b0;
      end
   end

   // Load data is broadcast; only the lane with wait low is meaningful.
   assign iload = {CPUS{ramload}};
   assign dload = {CPUS{ramload}};

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

The memory arbiter sits directly downstream of the per-CPU instruction and data caches and multiplexes their word requests onto the single RAM port. It grants one requester at a time and holds that grant until RAM reports the access complete. Completion is signalled to the cache by dropping that requester's wait flag for exactly one cycle, with load data valid in the same cycle. Data requests outrank instruction requests, and CPUs rotate round-robin within each class.

## Interface
Parameters:
- CPUS, 2, number of CPUs; each CPU has one I-port and one D-port.
- WORD_W, 32, data and address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  CPUS  instruction read request, per CPU.
- iaddr  in  CPUS×WORD_W  instruction address, per CPU.
- iwait  out  CPUS  1 = request not complete.
- iload  out  CPUS×WORD_W  instruction data.
- dREN, dWEN  in  CPUS each  data read / write request, per CPU.
- daddr, dstore  in  CPUS×WORD_W each  data address / write data.
- dwait  out  CPUS  1 = request not complete.
- dload  out  CPUS×WORD_W  data read data.
- ramREN, ramWEN  out  1 each  RAM read / write strobe.
- ramaddr, ramstore  out  WORD_W each  RAM address / write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS (done this cycle), 3 ERROR.

## Operation
- States: IDLE and XFER.
- Registered state: grant_cpu, grant_is_d, grant_is_wr, rr_ptr (last-serviced CPU).

IDLE:
- Evaluate requests every cycle.
- If any dREN|dWEN is set, the D class wins; otherwise the I class.
- Within the winning class, pick the first requesting CPU scanning from rr_ptr+1 modulo CPUS.
- For a D grant where both dWEN and dREN are set, the access is a write.
- Latch the grant and go to XFER.
- With no request, stay in IDLE.

XFER:
- Drive the RAM port combinationally from the latched grant:
  - ramaddr = granted address.
  - ramstore = dstore for writes.
  - ramWEN = grant_is_wr.
  - ramREN = !grant_is_wr.
- ramstate==ACCESS: drop the granted wait flag in this cycle only. Set rr_ptr ← grant_cpu. Return to IDLE.
- ramstate==ERROR: keep wait asserted, return to IDLE, and re-arbitrate. The request is retried and rr_ptr is unchanged.
- If the granted request line drops before completion: abort, deassert RAM strobes next cycle, return to IDLE, rr_ptr unchanged.

Output rules:
- All iload and dload lanes carry ramload (broadcast). Only the lane whose wait is low is meaningful.
- Every non-granted wait bit is 1 at all times.
- ramREN and ramWEN are never both 1. Both are 0 in IDLE; ramaddr and ramstore are 0 in IDLE.

Reset:
- state ← IDLE, rr_ptr ← CPUS-1, grant registers ← 0.
- All iwait and dwait = 1.
- ramREN = ramWEN = 0; ramaddr = ramstore = 0.
- Loads equal ramload; they are not registered.
- Reset asserted during XFER abandons the access at the next edge; no wait pulse is produced.

## Timing
- Request visible at edge N in IDLE → grant registered at N+1 → RAM strobes asserted from cycle N+1.
- Minimum latency is one cycle: ramstate==ACCESS in the first XFER cycle gives wait low in cycle N+1.
- Each additional BUSY cycle adds one cycle.
- The wait-low pulse is exactly one cycle wide. The cache must sample load and may drop its request at that edge.
- One IDLE cycle separates back-to-back grants. Peak throughput is one access per two cycles.
- Simultaneous requests resolve by priority: D over I, then round-robin. No requester starves: a pending D request is served within CPUS grants, and an I request as soon as no D is pending.

## Test plan
- Single I read: CPU0 iREN=1, iaddr=0x40, ramstate=ACCESS with ramload=0x8C010004 → ramREN=1, ramaddr=0x40 the cycle after request; iwait[0]=0 for one cycle with iload[0]=0x8C010004; back to IDLE.
- D over I: CPU0 iREN and CPU1 dWEN (daddr 0x100, dstore 0xDEADBEEF) asserted together → write granted first (ramWEN=1, ramstore=0xDEADBEEF); iwait[0] stays 1 until the next grant.
- Round-robin: CPU0 and CPU1 both hold dREN with 2 BUSY cycles per access → grant order 0,1,0,1; each dwait low pulse is 4 cycles after the previous one.
- Read+write same CPU: dREN=dWEN=1 → ramWEN=1, ramREN=0.
- ERROR retry: first access returns ERROR, second returns ACCESS → dwait stays 1 through the ERROR; the same request is re-granted after one IDLE cycle, then dwait low; rr_ptr advances only once.
- Abort/reset: request drops mid-BUSY → strobes clear next cycle, no wait pulse. Separately, RST=1 during XFER → next cycle all waits 1, RAM strobes 0, state IDLE.
